// File: rtl/par_serial_tx.sv
// par_serial_tx: shifts one byte per 8 clk_32f cycles out MSB-first, IDLE_SYM when no valid byte.
// Latency: byte sampled at load edge E appears on data_out after edges E+1 (MSB) .. E+8 (LSB).
// No backpressure: upstream aligns to load_strobe; define PAR_SERIAL_PREAMBLE_EN for the idle preamble.
module par_serial_tx #(
  parameter logic [7:0] IDLE_SYM     = 8'hBC,
  parameter int         PREAMBLE_LEN = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       load_strobe,
  output logic       sym_valid,
  output logic       link_active
);

  typedef enum logic {PREAMBLE = 1'b0, RUN = 1'b1} state_t;

  logic [2:0] cnt;
  logic [7:0] shreg;
  logic       vsh;
  state_t     state;
  logic [7:0] next_sym;
  logic       next_v;
  logic       load;

  // cnt==7 means the coming rising edge reloads shreg from next_sym
  assign load        = (cnt == 3'd7);
  assign load_strobe = load;

`ifdef PAR_SERIAL_PREAMBLE_EN
  state_t     state_nxt;
  logic [7:0] pre_cnt;
  logic [7:0] pre_cnt_nxt;

  // state register and preamble load counter
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state   <= PREAMBLE;
      pre_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      pre_cnt <= pre_cnt_nxt;
    end
  end

  // next state and symbol selection; the reset-loaded idle counts as the first preamble symbol
  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    next_sym    = IDLE_SYM;
    next_v      = 1'b0;
    case (state)
      PREAMBLE: begin
        if (load) begin
          if (pre_cnt == 8'(PREAMBLE_LEN - 2)) state_nxt = RUN;
          else                                 pre_cnt_nxt = pre_cnt + 8'd1;
        end
      end
      RUN: begin
        next_sym = valid_in ? data_in : IDLE_SYM;
        next_v   = valid_in;
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end
`else
  assign state = RUN;

  // without a preamble the upstream byte is honoured from the first load edge
  always_comb begin
    next_sym = valid_in ? data_in : IDLE_SYM;
    next_v   = valid_in;
  end
`endif

  // serialiser: shift every edge, reload on the load edge, outputs registered one bit behind shreg[7]
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      cnt         <= 3'd0;
      shreg       <= IDLE_SYM;
      vsh         <= 1'b0;
      data_out    <= 1'b0;
      sym_valid   <= 1'b0;
      link_active <= 1'b0;
    end else begin
      cnt         <= cnt + 3'd1;
      data_out    <= shreg[7];
      sym_valid   <= vsh;
      link_active <= (state == RUN);
      if (load) begin
        shreg <= next_sym;
        vsh   <= next_v;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_par_serial_tx.sv
// Directed bench for par_serial_tx; expectations depend on PAR_SERIAL_PREAMBLE_EN.
// Outputs sampled on the falling edge after each rising edge; inputs changed there too.
// Symbol windows: window k covers edges 8k+1..8k+8 and shows the symbol loaded at edge 8k.
module tb_par_serial_tx;

  logic       clk_32f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       load_strobe;
  logic       sym_valid;
  logic       link_active;

  int total = 0;
  int bad   = 0;

  par_serial_tx dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .load_strobe(load_strobe),
    .sym_valid  (sym_valid),
    .link_active(link_active)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Run nbits edges of one symbol window, checking bits MSB-first.
  // With tog set, valid_in flips every cycle but is 1 ahead of the window's load edge.
  task automatic run_sym(input string tag, input logic [7:0] sym, input logic v,
                         input logic la, input int nbits, input bit tog);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk_32f);
      @(negedge clk_32f);
      chk($sformatf("%s bit%0d data_out", tag, i), data_out, sym[7-i]);
      chk($sformatf("%s bit%0d sym_valid", tag, i), sym_valid, v);
      chk($sformatf("%s bit%0d link_active", tag, i), link_active, la);
      chk($sformatf("%s bit%0d load_strobe", tag, i), load_strobe, (i == 6));
      if (tog) begin
        if (i == 6)     valid_in = 1'b1;
        else if (i < 6) valid_in = ~valid_in;
      end
    end
  endtask

  // Assert reset between edges and check the outputs clear without a clock edge.
  task automatic mid_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, " data_out"}, data_out, 1'b0);
    chk({tag, " sym_valid"}, sym_valid, 1'b0);
    chk({tag, " link_active"}, link_active, 1'b0);
    chk({tag, " load_strobe"}, load_strobe, 1'b0);
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    #1;
    chk("rst data_out", data_out, 1'b0);
    chk("rst sym_valid", sym_valid, 1'b0);
    chk("rst link_active", link_active, 1'b0);
    chk("rst load_strobe", load_strobe, 1'b0);
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;

`ifdef PAR_SERIAL_PREAMBLE_EN
    // A5 held from release: four idle symbols, then A5 as data
    data_in  = 8'hA5;
    valid_in = 1'b1;
    run_sym("pre0", 8'hBC, 1'b0, 1'b0, 8, 1'b0);
    run_sym("pre1", 8'hBC, 1'b0, 1'b0, 8, 1'b0);
    run_sym("pre2", 8'hBC, 1'b0, 1'b0, 8, 1'b0);
    run_sym("pre3", 8'hBC, 1'b0, 1'b1, 8, 1'b0);
    run_sym("a5", 8'hA5, 1'b1, 1'b1, 8, 1'b0);
    mid_reset("rst_a");

    // IDLE_SYM value sent as valid data; reset hits at edge 35
    data_in = 8'hBC;
    run_sym("r1pre0", 8'hBC, 1'b0, 1'b0, 8, 1'b0);
    run_sym("r1pre1", 8'hBC, 1'b0, 1'b0, 8, 1'b0);
    run_sym("r1pre2", 8'hBC, 1'b0, 1'b0, 8, 1'b0);
    run_sym("r1pre3", 8'hBC, 1'b0, 1'b1, 8, 1'b0);
    run_sym("bcdata", 8'hBC, 1'b1, 1'b1, 3, 1'b0);
    mid_reset("rst_e35");

    // full preamble replays, then 5A, then a dropped valid gives idle
    data_in = 8'h5A;
    run_sym("r2pre0", 8'hBC, 1'b0, 1'b0, 8, 1'b0);
    run_sym("r2pre1", 8'hBC, 1'b0, 1'b0, 8, 1'b0);
    run_sym("r2pre2", 8'hBC, 1'b0, 1'b0, 8, 1'b0);
    run_sym("r2pre3", 8'hBC, 1'b0, 1'b1, 8, 1'b0);
    valid_in = 1'b0;
    run_sym("5a", 8'h5A, 1'b1, 1'b1, 8, 1'b0);
    run_sym("idle", 8'hBC, 1'b0, 1'b1, 8, 1'b0);
`else
    // changing bytes on successive load edges
    data_in  = 8'hEE;
    valid_in = 1'b1;
    run_sym("sym0", 8'hBC, 1'b0, 1'b1, 8, 1'b0);
    data_in = 8'hEF;
    run_sym("ee", 8'hEE, 1'b1, 1'b1, 8, 1'b0);
    data_in = 8'hF0;
    run_sym("ef", 8'hEF, 1'b1, 1'b1, 8, 1'b0);
    data_in = 8'h3C;
    run_sym("f0", 8'hF0, 1'b1, 1'b1, 8, 1'b0);

    // valid low at one load edge inserts an idle symbol
    valid_in = 1'b0;
    run_sym("3c_a", 8'h3C, 1'b1, 1'b1, 8, 1'b0);
    valid_in = 1'b1;
    run_sym("gap", 8'hBC, 1'b0, 1'b1, 8, 1'b0);
    data_in = 8'h5A;
    run_sym("3c_b", 8'h3C, 1'b1, 1'b1, 8, 1'b0);

    // valid_in toggling between load edges is ignored
    data_in = 8'hBC;
    run_sym("5a_tog", 8'h5A, 1'b1, 1'b1, 8, 1'b1);
    run_sym("bcdata", 8'hBC, 1'b1, 1'b1, 3, 1'b0);
    mid_reset("rst_mid");

    // restart: idle symbol first, then data from the first load
    data_in  = 8'hA5;
    valid_in = 1'b1;
    run_sym("r_sym0", 8'hBC, 1'b0, 1'b1, 8, 1'b0);
    valid_in = 1'b0;
    run_sym("r_a5", 8'hA5, 1'b1, 1'b1, 8, 1'b0);
    run_sym("r_idle", 8'hBC, 1'b0, 1'b1, 8, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/par_serial_tx.md
# par_serial_tx

Parallel-to-serial transmitter for the phy_tx path. It sits directly downstream of the 4:1 byte mux (L2). It takes the mux's 8-bit output and valid flag, one byte per 8 clk_32f cycles, and shifts it out MSB-first on a single serial line. When no valid byte is present, it sends the idle/comma symbol. After reset, an optional compile-time preamble of idle symbols runs before data is accepted.

## Interface
Parameters:
- IDLE_SYM, 8'hBC: symbol sent when no valid byte is present and during the preamble.
- PREAMBLE_LEN, 4: idle symbols sent after reset before data is honoured. Legal range 2..255.

Ports:
- clk_32f  in  1  serial bit clock; the only clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- data_in  in  8  byte from the L2 mux output; sampled only on load edges.
- valid_in  in  1  valid flag for data_in; sampled only on load edges.
- data_out  out  1  serial bit, registered, MSB of each symbol first.
- load_strobe  out  1  combinational, high while cnt==7; marks the cycle whose rising edge samples data_in/valid_in.
- sym_valid  out  1  registered; high while data_out carries bits of a data byte, low for IDLE_SYM bits.
- link_active  out  1  registered; high once the block has left the preamble.

## Operation
- Registers:
  - cnt[2:0]: bit counter.
  - shreg[7:0]: symbol shift register.
  - vsh: valid tag of the symbol in shreg.
  - state ∈ {PREAMBLE, RUN}.
  - pre_cnt[7:0]: preamble load counter.
  - data_out, sym_valid, link_active.
- Reset values:
  - cnt=0, shreg=IDLE_SYM, vsh=0, pre_cnt=0.
  - state=PREAMBLE (RUN when the macro is absent).
  - data_out=0, sym_valid=0, link_active=0, load_strobe=0.
- Every edge:
  - data_out<=shreg[7]; sym_valid<=vsh; cnt<=cnt+1 (wraps 7→0).
  - If cnt!=7: shreg<={shreg[6:0],1'b0}; vsh holds.
  - If cnt==7 (load edge): shreg<=next_sym, vsh<=next_v.
- Symbol selection per state:
  - PREAMBLE: next_sym=IDLE_SYM, next_v=0; data_in/valid_in ignored. At a load edge, if pre_cnt==PREAMBLE_LEN-2, state<=RUN; otherwise pre_cnt<=pre_cnt+1.
  - RUN: next_sym = valid_in ? data_in : IDLE_SYM; next_v=valid_in. RUN is terminal until reset.
- link_active <= (state==RUN) every edge.
- A byte equal to IDLE_SYM with valid_in=1 is sent as data (sym_valid=1); no escaping is done.
- Upstream holds data_in/valid_in stable across each load edge. load_strobe is the alignment reference for upstream.

## Timing
- Edge n = nth rising clk_32f edge after reset deasserts.
- Load edges are n = 8, 16, 24, ...
- Latency: a byte sampled at load edge E has its MSB on data_out after edge E+1 and its LSB after edge E+8, with sym_valid matching over the same window.
- Symbol 0 after reset is always IDLE_SYM (bits after edges 1–8), from the reset value of shreg.
- With the macro and PREAMBLE_LEN=4:
  - Loads at edges 8, 16, 24 are IDLE; state becomes RUN at edge 24.
  - link_active is high after edge 25.
  - First sampled byte is at edge 32; its MSB appears after edge 33.
- Reset mid-symbol: outputs clear asynchronously, the partial symbol is dropped, and the preamble replays in full after release.
- valid_in toggling between load edges has no effect.

## Configuration
- PAR_SERIAL_PREAMBLE_EN defined:
  - Reset state is PREAMBLE.
  - PREAMBLE_LEN idle symbols are sent (the reset-loaded symbol plus PREAMBLE_LEN-1 loads) before data_in is honoured.
- Not defined:
  - Reset state is RUN; pre_cnt and the PREAMBLE logic are absent.
  - link_active is high after edge 1.
  - The first load (edge 8) samples data_in; the first data MSB appears after edge 9.

## Test plan
- Macro on, PREAMBLE_LEN=4, valid_in=1, data_in=8'hA5 constant from reset release:
  - Edges 1–32 give 10111100 ×4 with sym_valid=0.
  - Edges 33–40 give 1,0,1,0,0,1,0,1 with sym_valid=1.
  - link_active rises after edge 25.
- Macro off, valid_in=1, data_in changes EE, EF, F0 on successive load edges 8/16/24:
  - Serial stream after edges 9–32 is 11101110, 11101111, 11110000, MSB-first, sym_valid=1.
- Macro off, valid_in=0 at load edge 16 and 1 elsewhere, data_in=8'h3C:
  - Edges 17–24 give 10111100 with sym_valid=0; the neighbouring symbols carry 00111100.
- Macro off, valid_in toggled every cycle except held 1 at each load edge:
  - Output identical to the constant-valid case.
- Reset asserted at edge 35, mid-symbol, released 3 cycles later:
  - data_out/sym_valid/link_active go 0 immediately without waiting for an edge.
  - Afterwards the stream restarts with IDLE_SYM and the full preamble (macro on).
- Macro on, valid_in=1, data_in=8'hBC:
  - After the preamble, the stream shows 10111100 with sym_valid=1.
